// File: rtl/ld_st_sl_seq.sv
// ============================================================================
//  Module      : ld_st_sl_seq
//  Description : Serial load sequencer feeding the load/store slice chain.
//                Accepts a word or a bulk set/clear command over valid/ready.
//                It then emits one data bit per cycle with l_s high, or a
//                single active-low set/clear pulse, followed by a done strobe.
//                Optional build macro LD_ST_SL_SEQ_PARITY_EN appends an
//                even-parity bit as an extra shift cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_st_sl_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] word_in,
  input  logic [1:0]       op,
  input  logic             word_vld,
  output logic             word_rdy,
  output logic             sl_in,
  output logic             l_s,
  output logic             sl_set,
  output logic             sl_clr,
  output logic             busy,
  output logic             done
);

`ifdef LD_ST_SL_SEQ_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_CMD   = 2'd2;
  localparam logic [1:0] c_FIN   = 2'd3;

  localparam logic [1:0] c_OP_SHIFT = 2'b00;
  localparam logic [1:0] c_OP_CLR   = 2'b01;
  localparam logic [1:0] c_OP_SET   = 2'b10;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] c_CNT_ZERO = '0;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             sl_in_q, sl_in_d;
  logic             l_s_q, l_s_d;
  logic             set_q, set_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [NBITS-1:0] w_load;
  logic             w_accept;

  // Word as it will be serialised: data MSB first, parity bit last if built in.
`ifdef LD_ST_SL_SEQ_PARITY_EN
  assign w_load = {word_in, ^word_in};
`else
  assign w_load = word_in;
`endif

  assign w_accept = word_vld && rdy_q && (state_q == c_IDLE);

  // Next-state and next-output computation; strobes default to inactive.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    sl_in_d = sl_in_q;
    l_s_d   = l_s_q;
    busy_d  = busy_q;
    set_d   = 1'b1;
    clr_d   = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          busy_d = 1'b1;
          rdy_d  = 1'b0;
          case (op)
            c_OP_SHIFT: begin
              // First bit goes out straight away; the rest stay queued in sreg.
              state_d = c_SHIFT;
              sl_in_d = w_load[NBITS-1];
              sreg_d  = w_load << 1;
              l_s_d   = 1'b1;
              cnt_d   = c_CNT_LAST;
            end
            c_OP_CLR: begin
              state_d = c_CMD;
              clr_d   = 1'b0;
            end
            c_OP_SET: begin
              state_d = c_CMD;
              set_d   = 1'b0;
            end
            default: begin
              // No-op: skip straight to the completion pulse.
              state_d = c_FIN;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      c_SHIFT: begin
        if (cnt_q == c_CNT_ZERO) begin
          state_d = c_FIN;
          l_s_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          sl_in_d = sreg_q[NBITS-1];
          sreg_d  = sreg_q << 1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      c_CMD: begin
        state_d = c_FIN;
        done_d  = 1'b1;
      end
      default: begin
        // FIN: done has been shown for one cycle, reopen for requests.
        state_d = c_IDLE;
        busy_d  = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= c_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      sl_in_q <= 1'b0;
      l_s_q   <= 1'b0;
      set_q   <= 1'b1;
      clr_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      sl_in_q <= sl_in_d;
      l_s_q   <= l_s_d;
      set_q   <= set_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign word_rdy = rdy_q;
  assign sl_in    = sl_in_q;
  assign l_s      = l_s_q;
  assign sl_set   = set_q;
  assign sl_clr   = clr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ld_st_sl_seq.sv
// ============================================================================
//  Module      : tb_ld_st_sl_seq
//  Description : Self-checking bench for ld_st_sl_seq. Requests come from a
//                vector table plus hand-written corner sequences; the expected
//                transfer is queued when driven and checked when done appears.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ld_st_sl_seq;

  localparam int W = 8;
`ifdef LD_ST_SL_SEQ_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] word_in = '0;
  logic [1:0]   op = 2'b00;
  logic         word_vld = 1'b0;
  logic         word_rdy, sl_in, l_s, sl_set, sl_clr, busy, done;

  ld_st_sl_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .word_in  (word_in),
    .op       (op),
    .word_vld (word_vld),
    .word_rdy (word_rdy),
    .sl_in    (sl_in),
    .l_s      (l_s),
    .sl_set   (sl_set),
    .sl_clr   (sl_clr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] word;
    int           e_ls;
    int           e_set;
    int           e_clr;
    int           e_lat;
  } vec_t;

  typedef struct {
    logic [1:0]    op;
    logic [NB-1:0] slice;
    int            e_ls;
    int            e_set;
    int            e_clr;
    int            e_lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents the slice chain should hold after a shift of w.
  function automatic logic [NB-1:0] load_val(input logic [W-1:0] w);
`ifdef LD_ST_SL_SEQ_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Edge-accurate record of acceptance and reset, sampled at the clock edge.
  logic acc_e = 1'b0;
  logic rst_e = 1'b0;
  int   cyc = 0;
  always @(posedge clk) begin
    acc_e <= word_vld && word_rdy && clr;
    rst_e <= !clr;
    cyc   <= cyc + 1;
  end

  // Monitor: models the slice chain and checks each transfer against the queue.
  bit            active = 0;
  bit            rdy_chk = 0;
  int            k = 0, n_ls = 0, n_set = 0, n_clr = 0;
  int            last_acc = 0, prev_acc = 0;
  logic [NB-1:0] slice = '0;
  exp_t          m_e;

  always begin
    @(posedge clk);
    #1;
    if (rst_e) begin
      active  = 0;
      rdy_chk = 0;
    end else begin
      if (rdy_chk) begin
        check("rdy_after_done", word_rdy, 1);
        rdy_chk = 0;
      end
      if (acc_e) begin
        check("accept_while_busy", active, 0);
        active   = 1;
        k        = 0;
        n_ls     = 0;
        n_set    = 0;
        n_clr    = 0;
        prev_acc = last_acc;
        last_acc = cyc;
      end else if (active) begin
        k++;
      end
      if (active) begin
        if (l_s) begin
          n_ls++;
          slice = {slice[NB-2:0], sl_in};
        end
        if (!sl_set) n_set++;
        if (!sl_clr) n_clr++;
        if (done) begin
          check("sb_nonempty_at_done", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            m_e = sb.pop_front();
            check("ls_cycles", n_ls, m_e.e_ls);
            check("set_pulses", n_set, m_e.e_set);
            check("clr_pulses", n_clr, m_e.e_clr);
            check("done_latency", k, m_e.e_lat);
            if (m_e.op == 2'b00) check("slice_contents", slice, m_e.slice);
          end
          active  = 0;
          rdy_chk = 1;
        end
      end else begin
        check("done_idle", done, 0);
      end
      check("strobe_excl", (int'(l_s) + int'(!sl_set) + int'(!sl_clr)) <= 1, 1);
      check("rdy_vs_busy", word_rdy, !busy);
    end
  end

  task automatic send(input vec_t v, input bit hold);
    exp_t e;
    int   t;
    @(negedge clk);
    op       = v.op;
    word_in  = v.word;
    word_vld = 1'b1;
    e.op    = v.op;
    e.slice = load_val(v.word);
    e.e_ls  = v.e_ls;
    e.e_set = v.e_set;
    e.e_clr = v.e_clr;
    e.e_lat = v.e_lat;
    sb.push_back(e);
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!acc_e && t < 50);
    check("accept_timeout", acc_e, 1);
    if (!hold) begin
      @(negedge clk);
      word_vld = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    check("done_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;

    tbl[0] = '{2'b00, 8'hA5, NB, 0, 0, NB};
    tbl[1] = '{2'b00, 8'h00, NB, 0, 0, NB};
    tbl[2] = '{2'b01, 8'h5A, 0,  0, 1, 1};
    tbl[3] = '{2'b10, 8'h33, 0,  1, 0, 1};
    tbl[4] = '{2'b11, 8'hFF, 0,  0, 0, 0};
    tbl[5] = '{2'b00, 8'h81, NB, 0, 0, NB};
    tbl[6] = '{2'b00, 8'h07, NB, 0, 0, NB};
    tbl[7] = '{2'b00, 8'hFF, NB, 0, 0, NB};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_word_rdy", word_rdy, 1);
    check("rst_sl_in", sl_in, 0);
    check("rst_l_s", l_s, 0);
    check("rst_sl_set", sl_set, 1);
    check("rst_sl_clr", sl_clr, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    clr = 1'b1;

    // Table vectors, one transfer at a time
    for (int i = 0; i < 8; i++) begin
      send(tbl[i], 1'b0);
      wait_idle();
    end

    // Clear then set back-to-back with word_vld held high
    v = '{2'b01, 8'h00, 0, 0, 1, 1};
    send(v, 1'b1);
    v = '{2'b10, 8'h00, 0, 1, 0, 1};
    send(v, 1'b0);
    wait_idle();
    check("b2b_accept_gap", last_acc - prev_acc, 3);

    // A request pulsed during the shift of 0xFF must be ignored
    v = '{2'b00, 8'hFF, NB, 0, 0, NB};
    send(v, 1'b0);
    repeat (2) @(negedge clk);
    op       = 2'b00;
    word_in  = 8'h00;
    word_vld = 1'b1;
    @(negedge clk);
    word_vld = 1'b0;
    wait_idle();

    // Reset in the middle of a 0x3C shift
    v = '{2'b00, 8'h3C, NB, 0, 0, NB};
    send(v, 1'b0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_l_s", l_s, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_word_rdy", word_rdy, 1);
    check("midrst_sl_set", sl_set, 1);
    check("midrst_sl_clr", sl_clr, 1);
    @(negedge clk);
    clr = 1'b1;
    sb.delete();
    repeat (14) @(negedge clk);

    // A fresh transfer after the aborted one still completes normally
    v = '{2'b00, 8'hC3, NB, 0, 0, NB};
    send(v, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_empty_at_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
